dcache_array_ctrl: RTL and testbench

DCACHE_ARRAY_CTRL -- requirements
Module: dcache_array_ctrl

---
 rtl/dcache_array_ctrl.sv | 156 +++++++++++++++
 tb/tb_dcache_array_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_array_ctrl.sv
// dcache_array_ctrl: direct-mapped D$ valid/tag/line array controller with
// post-reset sweep, line fill, write-through and invalidate sequencing.
// Build option: DCACHE_WRITE_THROUGH_UPDATE_EN (write-through updates a hit line).
module dcache_array_ctrl #(
  parameter int IndexWidth = 4,
  parameter int TagWidth   = 26,
  parameter int LineWidth  = 128
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  cmdValid,
  output logic                  cmdReady,
  input  logic [1:0]            command,
  input  logic [IndexWidth-1:0] cmdIndex,
  input  logic [TagWidth-1:0]   cmdTag,
  input  logic [LineWidth-1:0]  cmdLine,
  output logic                  done,
  output logic [LineWidth-1:0]  doneLine,
  input  logic [IndexWidth-1:0] lookupIndex,
  input  logic [TagWidth-1:0]   lookupTag,
  output logic                  lookupHit,
  output logic [LineWidth-1:0]  lookupLine,
  output logic [29:0]           memAddr,
  output logic                  memReadEnable,
  output logic                  memWriteEnable,
  output logic [LineWidth-1:0]  memWriteValue,
  input  logic                  memReadDone,
  input  logic [LineWidth-1:0]  memReadValue,
  input  logic                  memWriteDone,
  output logic                  resetBusy
);

  localparam int Entries = 1 << IndexWidth;

  localparam logic [1:0] CmdNone    = 2'd0;
  localparam logic [1:0] CmdWrite   = 2'd1;
  localparam logic [1:0] CmdReplace = 2'd2;
  localparam logic [1:0] CmdInval   = 2'd3;

  localparam logic [2:0] Sweep    = 3'd0;
  localparam logic [2:0] Idle     = 3'd1;
  localparam logic [2:0] MemWrite = 3'd2;
  localparam logic [2:0] MemRead  = 3'd3;
  localparam logic [2:0] Done     = 3'd4;

  logic [2:0]            state;
  logic [IndexWidth-1:0] sweep_idx;
  logic [IndexWidth-1:0] req_index;
  logic [TagWidth-1:0]   req_tag;
  logic                  accept;

  logic                  valid_q [Entries];
  logic [TagWidth-1:0]   tag_q   [Entries];
  logic [LineWidth-1:0]  line_q  [Entries];

  assign accept         = cmdValid && cmdReady;
  assign cmdReady       = (state == Idle);
  assign done           = (state == Done);
  assign memReadEnable  = (state == MemRead);
  assign memWriteEnable = (state == MemWrite);
  assign resetBusy      = (state == Sweep);

`ifdef DCACHE_WRITE_THROUGH_UPDATE_EN
  logic req_hit;
  assign req_hit = valid_q[req_index] && (tag_q[req_index] == req_tag);
`else
  logic cmd_hit;
  assign cmd_hit = valid_q[cmdIndex] && (tag_q[cmdIndex] == cmdTag);
`endif

  // Sequencer: sweep after reset, then accept and run one command at a time
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state         <= Sweep;
      sweep_idx     <= '0;
      req_index     <= '0;
      req_tag       <= '0;
      memAddr       <= '0;
      memWriteValue <= '0;
      doneLine      <= '0;
    end else begin
      unique case (state)
        Sweep: begin
          sweep_idx <= sweep_idx + IndexWidth'(1);
          if (&sweep_idx) begin
            state <= Idle;
          end
        end
        Idle: begin
          if (accept) begin
            req_index     <= cmdIndex;
            req_tag       <= cmdTag;
            memAddr       <= 30'({cmdTag, cmdIndex});
            memWriteValue <= cmdLine;
            unique case (command)
              CmdWrite:   state <= MemWrite;
              CmdReplace: state <= MemRead;
              CmdNone:    state <= Done;
              CmdInval:   state <= Done;
            endcase
          end
        end
        MemWrite: begin
          if (memWriteDone) begin
            state <= Done;
          end
        end
        MemRead: begin
          if (memReadDone) begin
            doneLine <= memReadValue;
            state    <= Done;
          end
        end
        Done: begin
          state <= Idle;
        end
        default: begin
          state <= Sweep;
        end
      endcase
    end
  end

  // Entry array updates: sweep clears, invalidate, write-through policy, fill
  always_ff @(posedge clk) begin
    if (state == Sweep) begin
      valid_q[sweep_idx] <= 1'b0;
    end else if (accept && command == CmdInval) begin
      valid_q[cmdIndex] <= 1'b0;
`ifdef DCACHE_WRITE_THROUGH_UPDATE_EN
    end else if (state == MemWrite && memWriteDone && req_hit) begin
      line_q[req_index] <= memWriteValue;
`else
    end else if (accept && command == CmdWrite && cmd_hit) begin
      valid_q[cmdIndex] <= 1'b0;
`endif
    end else if (state == MemRead && memReadDone) begin
      valid_q[req_index] <= 1'b1;
      tag_q[req_index]   <= req_tag;
      line_q[req_index]  <= memReadValue;
    end
  end

  // Registered lookup port; reads pre-update contents on a colliding edge
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      lookupHit  <= 1'b0;
      lookupLine <= '0;
    end else begin
      lookupHit  <= (state != Sweep) && valid_q[lookupIndex] &&
                    (tag_q[lookupIndex] == lookupTag);
      lookupLine <= line_q[lookupIndex];
    end
  end

endmodule

// File: tb/tb_dcache_array_ctrl.sv
// tb_dcache_array_ctrl: directed stimulus with a done/lookup scoreboard
// popped by a negedge monitor.
module tb_dcache_array_ctrl;

  localparam logic [1:0] CNone = 2'd0;
  localparam logic [1:0] CWt   = 2'd1;
  localparam logic [1:0] CRep  = 2'd2;
  localparam logic [1:0] CInv  = 2'd3;

  logic         clk = 1'b0;
  logic         rstN;
  logic         cmdValid;
  logic         cmdReady;
  logic [1:0]   command;
  logic [3:0]   cmdIndex;
  logic [25:0]  cmdTag;
  logic [127:0] cmdLine;
  logic         done;
  logic [127:0] doneLine;
  logic [3:0]   lookupIndex;
  logic [25:0]  lookupTag;
  logic         lookupHit;
  logic [127:0] lookupLine;
  logic [29:0]  memAddr;
  logic         memReadEnable;
  logic         memWriteEnable;
  logic [127:0] memWriteValue;
  logic         memReadDone;
  logic [127:0] memReadValue;
  logic         memWriteDone;
  logic         resetBusy;

  dcache_array_ctrl dut (
    .clk(clk), .rstN(rstN),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .command(command),
    .cmdIndex(cmdIndex), .cmdTag(cmdTag), .cmdLine(cmdLine),
    .done(done), .doneLine(doneLine),
    .lookupIndex(lookupIndex), .lookupTag(lookupTag),
    .lookupHit(lookupHit), .lookupLine(lookupLine),
    .memAddr(memAddr), .memReadEnable(memReadEnable),
    .memWriteEnable(memWriteEnable), .memWriteValue(memWriteValue),
    .memReadDone(memReadDone), .memReadValue(memReadValue),
    .memWriteDone(memWriteDone), .resetBusy(resetBusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         chk;
    logic [127:0] line;
  } done_exp_t;

  typedef struct {
    logic         hit;
    logic         chk;
    logic [127:0] line;
  } lk_exp_t;

  done_exp_t do_q[$];
  lk_exp_t   lk_q[$];

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic lk_req = 1'b0;
  logic lk_due = 1'b0;

  localparam logic [127:0] LA5 = {16{8'hA5}};
  localparam logic [127:0] LC3 = {16{8'hC3}};
  localparam logic [127:0] L5A = {16{8'h5A}};
  localparam logic [127:0] L77 = {16{8'h77}};

  function automatic void chk(input string nm, input logic [127:0] act,
                              input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic void fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: bound expired", nm);
  endfunction

  // lookup response is due one edge after the request is presented
  always @(posedge clk) lk_due <= lk_req;

  // monitor: pop and compare whenever the DUT presents a response
  always @(negedge clk) begin
    if (done) begin
      if (do_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done_unexpected: got done=1 want done=0");
      end else begin
        done_exp_t e;
        e = do_q.pop_front();
        done_cnt++;
        if (e.chk) chk("done_line", doneLine, e.line);
      end
    end
    if (lk_due) begin
      if (lk_q.size() == 0) begin
        fail("lookup_queue_empty");
      end else begin
        lk_exp_t l;
        l = lk_q.pop_front();
        chk("lookup_hit", {127'd0, lookupHit}, {127'd0, l.hit});
        if (l.chk) chk("lookup_line", lookupLine, l.line);
      end
    end
  end

  task automatic do_lookup(input logic [3:0] idx, input logic [25:0] tg,
                           input logic hit, input logic [127:0] ln);
    @(posedge clk); #1;
    lookupIndex = idx;
    lookupTag = tg;
    lk_req = 1'b1;
    lk_q.push_back('{hit, hit, ln});
    @(posedge clk); #1;
    lk_req = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] c, input logic [3:0] idx,
                          input logic [25:0] tg, input logic [127:0] ln,
                          input logic push, input logic [127:0] exp);
    int n = 0;
    @(posedge clk); #1;
    cmdValid = 1'b1;
    command = c;
    cmdIndex = idx;
    cmdTag = tg;
    cmdLine = ln;
    if (push) do_q.push_back('{1'b1, exp});
    @(negedge clk);
    while (!cmdReady && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!cmdReady) fail("accept_timeout");
    @(posedge clk); #1;
    cmdValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((do_q.size() != 0 || lk_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (do_q.size() != 0 || lk_q.size() != 0) begin
      fail("drain_timeout");
      do_q.delete();
      lk_q.delete();
    end
  endtask

  task automatic do_replace(input logic [3:0] idx, input logic [25:0] tg,
                            input logic [127:0] val, input int lat,
                            input logic lk_en, input logic lk_hit,
                            input logic [127:0] lk_line);
    send_cmd(CRep, idx, tg, '0, 1'b1, val);
    @(negedge clk);
    chk("rep_mre", {127'd0, memReadEnable}, 128'd1);
    chk("rep_mwe", {127'd0, memWriteEnable}, 128'd0);
    chk("rep_addr", {98'd0, memAddr}, {98'd0, tg, idx});
    repeat (lat - 1) begin
      @(posedge clk); #1;
    end
    memReadDone = 1'b1;
    memReadValue = val;
    if (lk_en) begin
      lookupIndex = idx;
      lookupTag = tg;
      lk_req = 1'b1;
      lk_q.push_back('{lk_hit, lk_hit, lk_line});
    end
    @(posedge clk); #1;
    memReadDone = 1'b0;
    lk_req = 1'b0;
    drain();
  endtask

  task automatic check_sweep(input string nm);
    int busy = 0;
    while (busy < 40) begin
      @(negedge clk);
      if (!resetBusy) break;
      busy++;
    end
    chk({nm, "_busy_cycles"}, 128'(busy), 128'd16);
    chk({nm, "_ready_after"}, {127'd0, cmdReady}, 128'd1);
  endtask

  initial begin
    int base;
    rstN = 1'b0;
    cmdValid = 1'b0;
    command = CNone;
    cmdIndex = '0;
    cmdTag = '0;
    cmdLine = '0;
    lookupIndex = '0;
    lookupTag = '0;
    memReadDone = 1'b0;
    memReadValue = '0;
    memWriteDone = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {127'd0, resetBusy}, 128'd1);
    chk("rst_ready", {127'd0, cmdReady}, 128'd0);
    chk("rst_done", {127'd0, done}, 128'd0);
    chk("rst_mre", {127'd0, memReadEnable}, 128'd0);
    chk("rst_mwe", {127'd0, memWriteEnable}, 128'd0);
    chk("rst_addr", {98'd0, memAddr}, 128'd0);
    chk("rst_hit", {127'd0, lookupHit}, 128'd0);
    chk("rst_doneline", doneLine, 128'd0);
    @(posedge clk); #1;
    rstN = 1'b1;
    check_sweep("sweep1");

    do_lookup(4'd3, 26'h155, 1'b0, '0);
    do_lookup(4'd0, 26'h0, 1'b0, '0);
    drain();

    do_replace(4'd3, 26'h155, LA5, 5, 1'b0, 1'b0, '0);
    do_lookup(4'd3, 26'h155, 1'b1, LA5);
    do_lookup(4'd3, 26'h154, 1'b0, '0);
    do_lookup(4'd4, 26'h155, 1'b0, '0);
    drain();

    do_replace(4'd5, 26'h0AA, LC3, 2, 1'b0, 1'b0, '0);

    // write-through with a second command held pending
    send_cmd(CWt, 4'd3, 26'h155, 128'h1234, 1'b1, LC3);
    base = done_cnt;
    fork
      send_cmd(CNone, 4'd0, 26'h0, '0, 1'b1, LC3);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("wt_ready_low", {127'd0, cmdReady}, 128'd0);
          chk("wt_mwe", {127'd0, memWriteEnable}, 128'd1);
        end
        chk("wt_mre", {127'd0, memReadEnable}, 128'd0);
        chk("wt_value", memWriteValue, 128'h1234);
        chk("wt_addr", {98'd0, memAddr}, 128'h1553);
        @(posedge clk); #1;
        memWriteDone = 1'b1;
        @(posedge clk); #1;
        memWriteDone = 1'b0;
      end
    join
    chk("second_after_done", 128'(done_cnt - base), 128'd1);
    drain();
`ifdef DCACHE_WRITE_THROUGH_UPDATE_EN
    do_lookup(4'd3, 26'h155, 1'b1, 128'h1234);
`else
    do_lookup(4'd3, 26'h155, 1'b0, '0);
`endif
    drain();

    // non-matching write-through leaves the entry alone
    send_cmd(CWt, 4'd5, 26'h0AB, 128'h9999, 1'b1, LC3);
    @(negedge clk);
    chk("wt2_value", memWriteValue, 128'h9999);
    @(posedge clk); #1;
    memWriteDone = 1'b1;
    @(posedge clk); #1;
    memWriteDone = 1'b0;
    drain();
    do_lookup(4'd5, 26'h0AA, 1'b1, LC3);
    drain();

    // refill index 3 with a colliding lookup on the fill edge
`ifdef DCACHE_WRITE_THROUGH_UPDATE_EN
    do_replace(4'd3, 26'h155, L5A, 3, 1'b1, 1'b1, 128'h1234);
`else
    do_replace(4'd3, 26'h155, L5A, 3, 1'b1, 1'b0, '0);
`endif
    do_lookup(4'd3, 26'h155, 1'b1, L5A);
    drain();

    send_cmd(CInv, 4'd3, 26'h155, '0, 1'b1, L5A);
    @(negedge clk);
    chk("inv_done_timing", {127'd0, done}, 128'd1);
    drain();
    do_lookup(4'd3, 26'h155, 1'b0, '0);
    do_lookup(4'd5, 26'h0AA, 1'b1, LC3);
    drain();

    do_replace(4'd9, 26'h2, L77, 1, 1'b0, 1'b0, '0);
    do_lookup(4'd9, 26'h2, 1'b1, L77);
    drain();

    // reset during a fill
    send_cmd(CRep, 4'd7, 26'h3, '0, 1'b0, '0);
    @(negedge clk);
    chk("mid_mre_before", {127'd0, memReadEnable}, 128'd1);
    #2;
    rstN = 1'b0;
    #1;
    chk("mid_mre_drop", {127'd0, memReadEnable}, 128'd0);
    chk("mid_busy", {127'd0, resetBusy}, 128'd1);
    chk("mid_addr", {98'd0, memAddr}, 128'd0);
    memReadDone = 1'b1;
    memReadValue = L77;
    @(posedge clk); #1;
    memReadDone = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    check_sweep("sweep2");
    do_lookup(4'd9, 26'h2, 1'b0, '0);
    do_lookup(4'd5, 26'h0AA, 1'b0, '0);
    drain();
    send_cmd(CNone, 4'd0, 26'h0, '0, 1'b1, 128'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time bound");
    $fatal(1);
  end

endmodule
